// File: rtl/player_source_mux_n.sv
// player_source_mux_n: per-player source select between local control and the
// UART remote path, with frame-aligned start/stop, a remote sync phase and
// per-remote staleness timeout (hold last value, report link loss).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | not running; every player shown at its start position
// SYNC   | local player live; waiting for a first strobe from each remote
// RUN    | all remotes live; per-remote staleness counters running
// LOST   | at least one remote stale; its position held, collision masked
//
// local_id carries one bit more than an index needs so that an out-of-range
// player number can actually be presented and flagged through cfg_err.
module player_source_mux_n #(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 8,
  parameter int TIMEOUT   = 1_000_000,
  parameter logic [N_PLAYERS*COORD_W-1:0] START_X = {8'd200, 8'd40},
  parameter logic [N_PLAYERS*COORD_W-1:0] START_Y = {8'd120, 8'd120},
  localparam int ID_W = $clog2(N_PLAYERS) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic [ID_W-1:0]                local_id,
  input  logic                           frame_tick,
  input  logic [N_PLAYERS*COORD_W-1:0]   ctrl_x,
  input  logic [N_PLAYERS*COORD_W-1:0]   ctrl_y,
  input  logic [N_PLAYERS-1:0]           ctrl_coll,
  input  logic [N_PLAYERS*COORD_W-1:0]   uart_x,
  input  logic [N_PLAYERS*COORD_W-1:0]   uart_y,
  input  logic [N_PLAYERS-1:0]           uart_coll,
  input  logic [N_PLAYERS-1:0]           uart_valid,
  output logic [N_PLAYERS*COORD_W-1:0]   cur_x,
  output logic [N_PLAYERS*COORD_W-1:0]   cur_y,
  output logic [N_PLAYERS-1:0]           collision,
  output logic [N_PLAYERS-1:0]           stale,
  output logic                           link_lost,
  output logic                           active,
  output logic                           cfg_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_LOST} state_t;

  state_t                              state_q, state_d;
  logic [ID_W-1:0]                     local_q, local_d;
  logic                                cfg_err_q, cfg_err_d;
  logic [N_PLAYERS-1:0][COORD_W-1:0]   hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic [N_PLAYERS-1:0]                hold_c_q, hold_c_d;
  logic [N_PLAYERS-1:0]                seen_q, seen_d;
  logic [N_PLAYERS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_PLAYERS-1:0][COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [N_PLAYERS-1:0]                coll_q, coll_d;
  logic [N_PLAYERS-1:0]                stale_q, stale_d;
  logic                                link_lost_q, link_lost_d;
  logic                                active_q, active_d;
  logic [N_PLAYERS-1:0]                loc_mask;
  logic                                start_ok, counting, all_seen, any_stale;

  // Next-state, hold/counter updates and registered-output values.
  always_comb begin
    state_d   = state_q;
    local_d   = local_q;
    cfg_err_d = cfg_err_q;
    hold_x_d  = hold_x_q;
    hold_y_d  = hold_y_q;
    hold_c_d  = hold_c_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    stale_d   = '0;
    loc_mask  = '0;
    all_seen  = 1'b1;
    any_stale = 1'b0;
    cur_x_d   = START_X;
    cur_y_d   = START_Y;
    coll_d    = '0;
    counting  = (state_q == S_RUN) || (state_q == S_LOST);
    start_ok  = (state_q == S_IDLE) && frame_tick && run &&
                (local_id < ID_W'(N_PLAYERS));

    if ((state_q == S_IDLE) && frame_tick && run) begin
      if (start_ok) begin
        local_d   = local_id;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    for (int i = 0; i < N_PLAYERS; i++) begin
      loc_mask[i] = (local_d == ID_W'(i));
    end

    for (int i = 0; i < N_PLAYERS; i++) begin
      if (state_q == S_IDLE) begin
        hold_x_d[i] = START_X[i*COORD_W +: COORD_W];
        hold_y_d[i] = START_Y[i*COORD_W +: COORD_W];
        hold_c_d[i] = 1'b0;
        seen_d[i]   = 1'b0;
        cnt_d[i]    = '0;
      end else if (!loc_mask[i]) begin
        if (uart_valid[i]) begin
          hold_x_d[i] = uart_x[i*COORD_W +: COORD_W];
          hold_y_d[i] = uart_y[i*COORD_W +: COORD_W];
          hold_c_d[i] = uart_coll[i];
          seen_d[i]   = 1'b1;
        end
        if (counting) begin
          if (uart_valid[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        stale_d[i] = counting && (cnt_d[i] == CNT_MAX);
      end
      if (!loc_mask[i] && !seen_d[i]) begin
        all_seen = 1'b0;
      end
    end
    any_stale = |stale_d;

    case (state_q)
      S_IDLE:  if (start_ok)   state_d = S_SYNC;
      S_SYNC:  if (all_seen)   state_d = S_RUN;
      S_RUN:   if (any_stale)  state_d = S_LOST;
      S_LOST:  if (!any_stale) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // A stop request at a frame boundary overrides every other event.
    if ((state_q != S_IDLE) && frame_tick && !run) begin
      state_d = S_IDLE;
      stale_d = '0;
    end

    if (state_d != S_IDLE) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (loc_mask[i]) begin
          cur_x_d[i] = ctrl_x[i*COORD_W +: COORD_W];
          cur_y_d[i] = ctrl_y[i*COORD_W +: COORD_W];
          coll_d[i]  = ctrl_coll[i];
        end else begin
          cur_x_d[i] = hold_x_d[i];
          cur_y_d[i] = hold_y_d[i];
          coll_d[i]  = hold_c_d[i] && !stale_d[i];
        end
      end
    end

    active_d = (state_d != S_IDLE);
    // Link loss stays reported for one cycle after leaving LOST.
    link_lost_d = active_d && ((state_d == S_LOST) || (state_q == S_LOST));
  end

  // State, hold registers, counters and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      local_q     <= '0;
      cfg_err_q   <= 1'b0;
      hold_x_q    <= START_X;
      hold_y_q    <= START_Y;
      hold_c_q    <= '0;
      seen_q      <= '0;
      cnt_q       <= '0;
      cur_x_q     <= START_X;
      cur_y_q     <= START_Y;
      coll_q      <= '0;
      stale_q     <= '0;
      link_lost_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      local_q     <= local_d;
      cfg_err_q   <= cfg_err_d;
      hold_x_q    <= hold_x_d;
      hold_y_q    <= hold_y_d;
      hold_c_q    <= hold_c_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      coll_q      <= coll_d;
      stale_q     <= stale_d;
      link_lost_q <= link_lost_d;
      active_q    <= active_d;
    end
  end

  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign collision = coll_q;
  assign stale     = stale_q;
  assign link_lost = link_lost_q;
  assign active    = active_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_player_source_mux_n.sv
// Bench for player_source_mux_n (2 players, 8-bit coordinates, timeout 16).
module tb_player_source_mux_n;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 16;

  logic            clk, rst_n, run, frame_tick;
  logic [1:0]      local_id;
  logic [N*W-1:0]  ctrl_x, ctrl_y, uart_x, uart_y, cur_x, cur_y;
  logic [N-1:0]    ctrl_coll, uart_coll, uart_valid, collision, stale;
  logic            link_lost, active, cfg_err;

  int n_total = 0;
  int n_pass  = 0;

  player_source_mux_n #(
    .N_PLAYERS(N), .COORD_W(W), .TIMEOUT(TO),
    .START_X({8'd200, 8'd40}), .START_Y({8'd120, 8'd120})
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .local_id(local_id),
    .frame_tick(frame_tick), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
    .ctrl_coll(ctrl_coll), .uart_x(uart_x), .uart_y(uart_y),
    .uart_coll(uart_coll), .uart_valid(uart_valid), .cur_x(cur_x),
    .cur_y(cur_y), .collision(collision), .stale(stale),
    .link_lost(link_lost), .active(active), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: game mode plus per-remote "cycles since last strobe".
  int mode;       // 0 idle, 1 waiting for remotes, 2 running, 3 link lost
  int prev_mode;
  int loc;
  bit m_cfg;
  int age [N];
  bit got [N];
  int hx [N], hy [N];
  bit hc [N];
  int ex_x [N], ex_y [N];
  bit ex_c [N], ex_s [N];
  bit ex_ll, ex_act;
  int sx [N] = '{40, 200};
  int sy [N] = '{120, 120};

  always @(posedge clk or negedge rst_n) begin : model
    bit any_st, all_got;
    if (!rst_n) begin
      mode = 0; prev_mode = 0; loc = 0; m_cfg = 0;
      for (int i = 0; i < N; i++) begin
        age[i] = 0; got[i] = 0; hx[i] = sx[i]; hy[i] = sy[i]; hc[i] = 0;
      end
    end else begin
      prev_mode = mode;
      if (mode == 0) begin
        if (frame_tick && run) begin
          if (int'(local_id) < N) begin
            mode = 1; loc = int'(local_id); m_cfg = 0;
            for (int i = 0; i < N; i++) begin
              age[i] = 0; got[i] = 0; hx[i] = sx[i]; hy[i] = sy[i]; hc[i] = 0;
            end
          end else begin
            m_cfg = 1;
          end
        end
      end else if (frame_tick && !run) begin
        mode = 0;
      end else begin
        any_st = 0; all_got = 1;
        for (int i = 0; i < N; i++) begin
          if (i != loc) begin
            if (uart_valid[i]) begin
              hx[i] = int'(uart_x[i*W +: W]);
              hy[i] = int'(uart_y[i*W +: W]);
              hc[i] = uart_coll[i];
              got[i] = 1;
            end
            if (mode >= 2) age[i] = uart_valid[i] ? 0 : ((age[i] < TO) ? age[i] + 1 : TO);
            if (mode >= 2 && age[i] == TO) any_st = 1;
            if (!got[i]) all_got = 0;
          end
        end
        if (mode == 1 && all_got) mode = 2;
        else if (mode == 2 && any_st) mode = 3;
        else if (mode == 3 && !any_st) mode = 2;
      end
    end
    for (int i = 0; i < N; i++) begin
      ex_s[i] = (mode >= 2) && (i != loc) && (age[i] == TO);
      if (mode == 0) begin
        ex_x[i] = sx[i]; ex_y[i] = sy[i]; ex_c[i] = 0;
      end else if (i == loc) begin
        ex_x[i] = int'(ctrl_x[i*W +: W]); ex_y[i] = int'(ctrl_y[i*W +: W]);
        ex_c[i] = ctrl_coll[i];
      end else begin
        ex_x[i] = hx[i]; ex_y[i] = hy[i]; ex_c[i] = hc[i] && !ex_s[i];
      end
    end
    ex_act = (mode != 0);
    ex_ll  = (mode != 0) && (mode == 3 || prev_mode == 3);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("cur_x[%0d]", i), int'(cur_x[i*W +: W]), ex_x[i]);
        chk($sformatf("cur_y[%0d]", i), int'(cur_y[i*W +: W]), ex_y[i]);
        chk($sformatf("collision[%0d]", i), int'(collision[i]), int'(ex_c[i]));
        chk($sformatf("stale[%0d]", i), int'(stale[i]), int'(ex_s[i]));
      end
      chk("link_lost", int'(link_lost), int'(ex_ll));
      chk("active", int'(active), int'(ex_act));
      chk("cfg_err", int'(cfg_err), int'(m_cfg));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic r);
    run = r; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic strobe(input logic [N-1:0] v);
    uart_valid = v;
    @(negedge clk);
    uart_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; frame_tick = 1'b0; local_id = 2'd0;
    ctrl_x = '0; ctrl_y = '0; ctrl_coll = '0;
    uart_x = '0; uart_y = '0; uart_coll = '0; uart_valid = '0;
    step(2);
    rst_n = 1'b1;
    chk("reset cur_x", int'(cur_x), 16'hC828);
    chk("reset cur_y", int'(cur_y), 16'h7878);
    chk("reset active", int'(active), 0);

    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      step(1);
    end
    chk("idle cur_x", int'(cur_x), 16'hC828);
    chk("idle active", int'(active), 0);

    // Start with local player 0.
    ctrl_x = {8'd77, 8'd55}; ctrl_y = {8'd10, 8'd11}; ctrl_coll = 2'b01;
    local_id = 2'd0;
    tick(1'b1);
    chk("sync active", int'(active), 1);
    chk("sync cur_x", int'(cur_x), {8'd200, 8'd55});
    chk("sync coll", int'(collision), 2'b01);

    uart_x = {8'd90, 8'd0}; uart_y = {8'd51, 8'd0}; uart_coll = 2'b10;
    strobe(2'b10);
    chk("first remote x", int'(cur_x[15:8]), 90);
    chk("first remote coll", int'(collision), 2'b11);

    // Timeout: 15 quiet cycles still fine, the 16th marks it stale.
    step(15);
    chk("pre-timeout stale", int'(stale), 0);
    step(1);
    chk("timeout stale", int'(stale), 2'b10);
    chk("timeout link_lost", int'(link_lost), 1);
    chk("timeout hold x", int'(cur_x[15:8]), 90);
    chk("timeout coll masked", int'(collision), 2'b01);

    uart_x = {8'd91, 8'd0}; uart_coll = 2'b00;
    strobe(2'b10);
    chk("recover stale", int'(stale), 0);
    chk("recover x", int'(cur_x[15:8]), 91);
    chk("recover link_lost lag", int'(link_lost), 1);
    step(1);
    chk("link_lost cleared", int'(link_lost), 0);

    // Strobe on the cycle the counter would reach the timeout; local strobe ignored.
    step(14);
    uart_x = {8'd92, 8'd1};
    strobe(2'b11);
    chk("boundary stale", int'(stale), 0);
    chk("local ignores uart", int'(cur_x), {8'd92, 8'd55});
    step(15);
    chk("boundary again stale", int'(stale), 0);
    chk("boundary link_lost", int'(link_lost), 0);
    strobe(2'b10);

    // local_id change mid-frame has no effect.
    local_id = 2'd1;
    step(3);
    chk("midframe id active", int'(active), 1);
    chk("midframe id local x", int'(cur_x[7:0]), 55);

    // Stop at frame boundary.
    tick(1'b0);
    chk("stop cur_x", int'(cur_x), 16'hC828);
    chk("stop coll", int'(collision), 0);
    chk("stop active", int'(active), 0);

    // Out-of-range local player.
    local_id = 2'd2; run = 1'b1;
    step(2);
    chk("run midframe active", int'(active), 0);
    tick(1'b1);
    chk("cfg_err set", int'(cfg_err), 1);
    chk("cfg_err idle", int'(active), 0);
    step(2);

    // Restart as player 1.
    local_id = 2'd1;
    tick(1'b1);
    chk("cfg_err clear", int'(cfg_err), 0);
    chk("role1 cur_x", int'(cur_x), {8'd77, 8'd40});
    chk("role1 coll", int'(collision), 0);

    uart_x = {8'd92, 8'd16};
    strobe(2'b01);
    chk("role1 remote x", int'(cur_x), {8'd77, 8'd16});
    step(16);
    chk("role1 stale", int'(stale), 2'b01);
    chk("role1 link_lost", int'(link_lost), 1);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async cur_x", int'(cur_x), 16'hC828);
    chk("async cur_y", int'(cur_y), 16'h7878);
    chk("async link_lost", int'(link_lost), 0);
    chk("async stale", int'(stale), 0);
    chk("async active", int'(active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("post reset active", int'(active), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
